// File: rtl/mash_pkg.sv
// Shared types and constants for the MASH PWM chain sequencer.
package mash_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FILL  = 2'd2,
        ST_RUN   = 2'd3
    } mash_state_t;

    localparam int          MASH_FILL_STEPS = 4;
    localparam int          MASH_TGT_W      = 32;
    localparam logic [23:0] MASH_TGT_PREFIX = 24'h4995cd;

    // Full target word built from the default upper bits and a low byte.
    function automatic logic [MASH_TGT_W-1:0] mash_tgt(input logic [7:0] low);
        return {MASH_TGT_PREFIX, low};
    endfunction

endpackage

// File: rtl/mash_ctrl_if.sv
// Target offer channel: requester holds req/data until the one-cycle ack.
interface mash_ctrl_if
    import mash_pkg::*;
#(
    parameter int TGT_W = MASH_TGT_W
);

    logic             req;
    logic [TGT_W-1:0] data;
    logic             ack;

    modport master (output req, output data, input ack);
    modport slave  (input req, input data, output ack);

endinterface

// File: rtl/mash_ctrl_stepgen.sv
// Reloading down-counter producing a registered one-cycle step pulse.
module stepgen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    input  logic             step_en,
    input  logic [DIV_W-1:0] div,
    output logic             step
);

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cnt_nxt_s;
    logic             step_r;

    // Next count: load wins, otherwise count down and reload from div at zero.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (load) begin
            cnt_nxt_s = div;
        end else if (run) begin
            if (cnt_r == {DIV_W{1'b0}}) begin
                cnt_nxt_s = div;
            end else begin
                cnt_nxt_s = cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter and pulse registers; the pulse marks the cycle the count sits at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {DIV_W{1'b0}};
            step_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            step_r <= step_en && (cnt_nxt_s == {DIV_W{1'b0}});
        end
    end

    assign step = step_r;

endmodule

// File: rtl/mash_ctrl.sv
// Sequencer for the four-stage MASH PWM chain: step generation, pipeline
// clear/refill, target handshake and gated duty forwarding.
module mash_ctrl
    import mash_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FILL_STEPS = MASH_FILL_STEPS,
    parameter int TGT_W      = MASH_TGT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             hitless,
    input  logic [DIV_W-1:0] div,
    mash_ctrl_if.slave       tgt,
    output logic             step,
    output logic             clr,
    output logic [TGT_W-1:0] tgt_out,
    input  logic [15:0]      duty_in,
    output logic [15:0]      duty_out,
    output logic             duty_load,
    output logic             busy,
    output logic [1:0]       state
);

    localparam int FILL_W = $clog2(FILL_STEPS + 1);

    mash_state_t      state_r;
    mash_state_t      state_nxt_s;
    logic [FILL_W-1:0] fill_r;
    logic [FILL_W-1:0] fill_nxt_s;
    logic             pend_r;
    logic [TGT_W-1:0] pend_data_r;
    logic             ack_r;
    logic             clr_r;
    logic             busy_r;
    logic             duty_load_r;
    logic [15:0]      duty_out_r;
    logic [TGT_W-1:0] tgt_out_r;
    logic             step_s;
    logic             consume_s;
    logic             capture_s;
    logic             accept_s;
    logic             div_load_s;
    logic             div_run_s;
    logic             step_en_s;

    assign div_load_s = (state_r == ST_FLUSH);
    assign div_run_s  = (state_r == ST_FILL) || (state_r == ST_RUN);
    // Step is only issued into a cycle that is itself FILL or RUN, so a falling en suppresses it.
    assign step_en_s  = (state_nxt_s == ST_FILL) || (state_nxt_s == ST_RUN);

    stepgen #(
        .DIV_W (DIV_W)
    ) u_stepgen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (div_load_s),
        .run     (div_run_s),
        .step_en (step_en_s),
        .div     (div),
        .step    (step_s)
    );

    // Next-state, fill count and the per-cycle consume/capture decisions.
    always_comb begin
        state_nxt_s = state_r;
        fill_nxt_s  = fill_r;
        consume_s   = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (!en) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    consume_s   = pend_r;
                    fill_nxt_s  = {FILL_W{1'b0}};
                    state_nxt_s = ST_FILL;
                end
            end
            ST_FILL: begin
                if (!en) begin
                    state_nxt_s = ST_IDLE;
                end else if (step_s) begin
                    fill_nxt_s = fill_r + FILL_W'(1'b1);
                    if (fill_nxt_s == FILL_W'(FILL_STEPS)) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_nxt_s = ST_IDLE;
                end else if (step_s) begin
                    // A pending target without hitless swap forces a refill instead of a capture.
                    if (pend_r && !hitless) begin
                        state_nxt_s = ST_FLUSH;
                    end else begin
                        capture_s   = 1'b1;
                        consume_s   = pend_r;
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // A slot emptying this cycle can take the next offer at the same edge.
    assign accept_s = tgt.req && !ack_r && (!pend_r || consume_s);

    // FSM state and fill counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            fill_r  <= {FILL_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            fill_r  <= fill_nxt_s;
        end
    end

    // Pending target slot and its acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r      <= 1'b0;
            pend_data_r <= {TGT_W{1'b0}};
            ack_r       <= 1'b0;
        end else begin
            ack_r <= accept_s;
            if (accept_s) begin
                pend_r      <= 1'b1;
                pend_data_r <= tgt.data;
            end else if (consume_s) begin
                pend_r <= 1'b0;
            end else begin
                pend_r <= pend_r;
            end
        end
    end

    // Registered chain-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_r       <= 1'b0;
            busy_r      <= 1'b0;
            duty_load_r <= 1'b0;
            duty_out_r  <= 16'h0000;
            tgt_out_r   <= {TGT_W{1'b0}};
        end else begin
            clr_r       <= (state_nxt_s == ST_FLUSH);
            busy_r      <= (state_nxt_s == ST_FLUSH) || (state_nxt_s == ST_FILL);
            duty_load_r <= capture_s;
            if (capture_s) begin
                duty_out_r <= duty_in;
            end else begin
                duty_out_r <= duty_out_r;
            end
            if (consume_s) begin
                tgt_out_r <= pend_data_r;
            end else begin
                tgt_out_r <= tgt_out_r;
            end
        end
    end

    assign tgt.ack   = ack_r;
    assign step      = step_s;
    assign clr       = clr_r;
    assign busy      = busy_r;
    assign duty_load = duty_load_r;
    assign duty_out  = duty_out_r;
    assign tgt_out   = tgt_out_r;
    assign state     = state_r;

endmodule

// File: tb/tb_mash_ctrl.sv
// Directed bench for mash_ctrl: cycle-exact checks of the start-up, target
// handshake, flush/hitless swaps, en drop, async reset and div=0.
module tb_mash_ctrl;
    import mash_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        hitless;
    logic [15:0] div;
    logic        step;
    logic        clr;
    logic [31:0] tgt_out;
    logic [15:0] duty_in;
    logic [15:0] duty_out;
    logic        duty_load;
    logic        busy;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mash_ctrl_if #(.TGT_W(32)) tgt_bus ();

    mash_ctrl #(
        .DIV_W      (16),
        .FILL_STEPS (4),
        .TGT_W      (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .hitless   (hitless),
        .div       (div),
        .tgt       (tgt_bus),
        .step      (step),
        .clr       (clr),
        .tgt_out   (tgt_out),
        .duty_in   (duty_in),
        .duty_out  (duty_out),
        .duty_load (duty_load),
        .busy      (busy),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Advance to the next sampling point (mid-cycle) and number the cycle.
    task automatic tick();
        @(negedge clk);
        cyc = cyc + 1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({step, clr, busy, duty_load, tgt_bus.ack, state} !== 7'b0) begin
            errors++;
            $display("FAIL reset_hold_ctl got=%b exp=%b", {step, clr, busy, duty_load, tgt_bus.ack, state}, 7'b0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if ({step, clr, busy, duty_load, tgt_bus.ack, state} !== 7'b0) begin
                errors++;
                $display("FAIL reset_ctl k=%0d got=%b exp=%b", k, {step, clr, busy, duty_load, tgt_bus.ack, state}, 7'b0);
            end
            checks++;
            if ({tgt_out, duty_out} !== 48'h0) begin
                errors++;
                $display("FAIL reset_data k=%0d got=%h exp=%h", k, {tgt_out, duty_out}, 48'h0);
            end
        end
    endtask

    task automatic test_startup();
        logic [6:0] exp_ctl;
        logic [1:0] exp_state;
        logic [15:0] exp_duty;
        duty_in = 16'h1234;
        cyc = 0;
        en = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            tick();
            exp_state = (cyc == 1) ? 2'd1 : (cyc <= 17) ? 2'd2 : 2'd3;
            exp_ctl = {(cyc >= 5) && ((cyc - 5) % 4 == 0), cyc == 1, cyc <= 17, cyc == 22, 1'b0, exp_state};
            exp_duty = (cyc >= 22) ? 16'h1234 : 16'h0000;
            checks++;
            if ({step, clr, busy, duty_load, tgt_bus.ack, state} !== exp_ctl) begin
                errors++;
                $display("FAIL startup_ctl cyc=%0d got=%b exp=%b", cyc, {step, clr, busy, duty_load, tgt_bus.ack, state}, exp_ctl);
            end
            checks++;
            if (duty_out !== exp_duty || tgt_out !== 32'h0) begin
                errors++;
                $display("FAIL startup_data cyc=%0d got=%h/%h exp=%h/%h", cyc, duty_out, tgt_out, exp_duty, 32'h0);
            end
        end
    endtask

    task automatic test_flush_target();
        logic [6:0] exp_ctl;
        logic [1:0] exp_state;
        logic [31:0] exp_tgt;
        logic [15:0] exp_duty;
        int busy_cnt;
        busy_cnt = 0;
        duty_in = 16'h5678;
        tgt_bus.data = mash_tgt(8'h80);
        tgt_bus.req = 1'b1;
        while (cyc < 47) begin
            tick();
            exp_state = (cyc <= 25) ? 2'd3 : (cyc == 26) ? 2'd1 : (cyc <= 42) ? 2'd2 : 2'd3;
            exp_ctl = {(cyc == 25) || ((cyc >= 30) && ((cyc - 30) % 4 == 0)), cyc == 26,
                       (cyc >= 26) && (cyc <= 42), cyc == 47, cyc == 23, exp_state};
            exp_tgt = (cyc >= 27) ? 32'h4995cd80 : 32'h0;
            exp_duty = (cyc >= 47) ? 16'h5678 : 16'h1234;
            checks++;
            if ({step, clr, busy, duty_load, tgt_bus.ack, state} !== exp_ctl) begin
                errors++;
                $display("FAIL flush_ctl cyc=%0d got=%b exp=%b", cyc, {step, clr, busy, duty_load, tgt_bus.ack, state}, exp_ctl);
            end
            checks++;
            if (tgt_out !== exp_tgt || duty_out !== exp_duty) begin
                errors++;
                $display("FAIL flush_data cyc=%0d got=%h/%h exp=%h/%h", cyc, tgt_out, duty_out, exp_tgt, exp_duty);
            end
            busy_cnt += int'(busy);
            if (cyc == 23) tgt_bus.req = 1'b0;
        end
        checks++;
        if (busy_cnt !== 17) begin
            errors++;
            $display("FAIL flush_busy_len got=%0d exp=%0d", busy_cnt, 17);
        end
    endtask

    task automatic test_hitless();
        logic [6:0] exp_ctl;
        logic [31:0] exp_tgt;
        logic [15:0] exp_duty;
        hitless = 1'b1;
        duty_in = 16'h9abc;
        tgt_bus.data = mash_tgt(8'h81);
        tgt_bus.req = 1'b1;
        while (cyc < 59) begin
            tick();
            exp_ctl = {(cyc >= 50) && ((cyc - 50) % 4 == 0), 1'b0, 1'b0,
                       (cyc >= 51) && ((cyc - 51) % 4 == 0), cyc == 48, 2'd3};
            exp_tgt = (cyc >= 51) ? 32'h4995cd81 : 32'h4995cd80;
            exp_duty = (cyc >= 51) ? 16'h9abc : 16'h5678;
            checks++;
            if ({step, clr, busy, duty_load, tgt_bus.ack, state} !== exp_ctl) begin
                errors++;
                $display("FAIL hitless_ctl cyc=%0d got=%b exp=%b", cyc, {step, clr, busy, duty_load, tgt_bus.ack, state}, exp_ctl);
            end
            checks++;
            if (tgt_out !== exp_tgt || duty_out !== exp_duty) begin
                errors++;
                $display("FAIL hitless_data cyc=%0d got=%h/%h exp=%h/%h", cyc, tgt_out, duty_out, exp_tgt, exp_duty);
            end
            if (cyc == 48) tgt_bus.req = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_ctl;
        logic [1:0] exp_state;
        logic [31:0] exp_tgt;
        en = 1'b0;
        hitless = 1'b0;
        while (cyc < 67) begin
            tick();
            exp_state = (cyc <= 65) ? 2'd0 : (cyc == 66) ? 2'd1 : 2'd2;
            exp_ctl = {1'b0, cyc == 66, cyc >= 66, 1'b0, (cyc == 61) || (cyc == 67), exp_state};
            exp_tgt = (cyc >= 67) ? 32'h4995cd90 : 32'h4995cd81;
            checks++;
            if ({step, clr, busy, duty_load, tgt_bus.ack, state} !== exp_ctl) begin
                errors++;
                $display("FAIL b2b_ctl cyc=%0d got=%b exp=%b", cyc, {step, clr, busy, duty_load, tgt_bus.ack, state}, exp_ctl);
            end
            checks++;
            if (tgt_out !== exp_tgt) begin
                errors++;
                $display("FAIL b2b_tgt cyc=%0d got=%h exp=%h", cyc, tgt_out, exp_tgt);
            end
            if (cyc == 60) begin
                tgt_bus.req = 1'b1;
                tgt_bus.data = mash_tgt(8'h90);
            end
            if (cyc == 61) tgt_bus.data = mash_tgt(8'h91);
            if (cyc == 65) en = 1'b1;
            if (cyc == 67) tgt_bus.req = 1'b0;
        end
    endtask

    task automatic test_en_drop_reset();
        logic [6:0] exp_ctl;
        logic [1:0] exp_state;
        logic [31:0] exp_tgt;
        logic [15:0] exp_duty;
        while (cyc < 80) begin
            tick();
            exp_state = (cyc <= 73) ? 2'd2 : 2'd0;
            exp_ctl = {cyc == 70, 1'b0, cyc <= 73, 1'b0, 1'b0, exp_state};
            checks++;
            if ({step, clr, busy, duty_load, tgt_bus.ack, state} !== exp_ctl) begin
                errors++;
                $display("FAIL endrop_ctl cyc=%0d got=%b exp=%b", cyc, {step, clr, busy, duty_load, tgt_bus.ack, state}, exp_ctl);
            end
            checks++;
            if (tgt_out !== 32'h4995cd90 || duty_out !== 16'h9abc) begin
                errors++;
                $display("FAIL endrop_data cyc=%0d got=%h/%h exp=%h/%h", cyc, tgt_out, duty_out, 32'h4995cd90, 16'h9abc);
            end
            if (cyc == 73) en = 1'b0;
        end
        en = 1'b1;
        duty_in = 16'hbeef;
        while (cyc < 102) begin
            tick();
            exp_state = (cyc == 81) ? 2'd1 : (cyc <= 97) ? 2'd2 : 2'd3;
            exp_ctl = {(cyc >= 85) && ((cyc - 85) % 4 == 0), cyc == 81, cyc <= 97, cyc == 102, 1'b0, exp_state};
            exp_tgt = (cyc >= 82) ? 32'h4995cd91 : 32'h4995cd90;
            exp_duty = (cyc >= 102) ? 16'hbeef : 16'h9abc;
            checks++;
            if ({step, clr, busy, duty_load, tgt_bus.ack, state} !== exp_ctl) begin
                errors++;
                $display("FAIL rerun_ctl cyc=%0d got=%b exp=%b", cyc, {step, clr, busy, duty_load, tgt_bus.ack, state}, exp_ctl);
            end
            checks++;
            if (tgt_out !== exp_tgt || duty_out !== exp_duty) begin
                errors++;
                $display("FAIL rerun_data cyc=%0d got=%h/%h exp=%h/%h", cyc, tgt_out, duty_out, exp_tgt, exp_duty);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({step, clr, busy, duty_load, tgt_bus.ack, state} !== 7'b0) begin
            errors++;
            $display("FAIL async_rst_ctl got=%b exp=%b", {step, clr, busy, duty_load, tgt_bus.ack, state}, 7'b0);
        end
        checks++;
        if ({tgt_out, duty_out} !== 48'h0) begin
            errors++;
            $display("FAIL async_rst_data got=%h exp=%h", {tgt_out, duty_out}, 48'h0);
        end
    endtask

    task automatic test_div_zero();
        logic [6:0] exp_ctl;
        logic [1:0] exp_state;
        logic [15:0] exp_duty;
        @(negedge clk);
        rst_n = 1'b1;
        div = 16'd0;
        duty_in = 16'h0f0f;
        cyc = 0;
        en = 1'b1;
        while (cyc < 8) begin
            tick();
            exp_state = (cyc == 1) ? 2'd1 : (cyc <= 5) ? 2'd2 : 2'd3;
            exp_ctl = {cyc >= 2, cyc == 1, cyc <= 5, cyc >= 7, 1'b0, exp_state};
            exp_duty = (cyc >= 7) ? 16'h0f0f : 16'h0000;
            checks++;
            if ({step, clr, busy, duty_load, tgt_bus.ack, state} !== exp_ctl) begin
                errors++;
                $display("FAIL div0_ctl cyc=%0d got=%b exp=%b", cyc, {step, clr, busy, duty_load, tgt_bus.ack, state}, exp_ctl);
            end
            checks++;
            if (duty_out !== exp_duty || tgt_out !== 32'h0) begin
                errors++;
                $display("FAIL div0_data cyc=%0d got=%h/%h exp=%h/%h", cyc, duty_out, tgt_out, exp_duty, 32'h0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        hitless = 1'b0;
        div = 16'd3;
        duty_in = 16'h0000;
        tgt_bus.req = 1'b0;
        tgt_bus.data = 32'h0;
        test_reset();
        test_startup();
        test_flush_target();
        test_hitless();
        test_back_to_back();
        test_en_drop_reset();
        test_div_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mash_ctrl.md
# mash_ctrl

Sequencer for the four-stage MASH PWM chain (four cascaded modulators, difference stages, four-input signed adder, `pwm16`). Generates the modulator step enable from a programmable divider. Clears and refills the pipeline when the chain starts or when the target changes. Accepts new targets through a req/ack handshake, and forwards the summed duty cycle to the PWM only once the pipeline holds valid data.

## Interface
Parameters:
- `DIV_W`, 16, divider counter width
- `FILL_STEPS`, 4, steps discarded after a clear (pipeline depth)
- `TGT_W`, 32, target word width

Ports:
- `clk`, in, 1, single system clock
- `rst_n`, in, 1, asynchronous active-low reset
- `en`, in, 1, run enable (level)
- `hitless`, in, 1, 1 = apply new target without clearing the pipeline
- `div`, in, DIV_W, step period minus one, in `clk` cycles
- `tgt_req`, in, 1, new target offered; held until `tgt_ack`
- `tgt_data`, in, TGT_W, offered target
- `tgt_ack`, out, 1, one-cycle accept pulse
- `step`, out, 1, one-cycle clock enable to the modulator chain
- `clr`, out, 1, one-cycle synchronous clear to the modulators and difference stages
- `tgt_out`, out, TGT_W, target driven into stage 1
- `duty_in`, in, 16, sum from the adder
- `duty_out`, out, 16, duty value to `pwm16`
- `duty_load`, out, 1, one-cycle strobe: `duty_out` is new
- `busy`, out, 1, high in FLUSH or FILL
- `state`, out, 2, current state, for debug LEDs

## Operation
- States: IDLE=0, FLUSH=1, FILL=2, RUN=3.
- Reset values: all outputs 0, `tgt_out`=0, pending slot empty, divider count 0, fill count 0.
- IDLE:
  - `step`=0.
  - `en`=1 -> FLUSH.
- FLUSH (exactly 1 cycle):
  - `clr`=1.
  - If the pending slot is full, `tgt_out` <= pending and the slot empties.
  - Divider count <= `div`; fill count <= 0.
  - -> FILL.
- FILL:
  - Divider decrements each cycle. At 0, `step`=1 and the count reloads from the current `div`.
  - Each step increments the fill count.
  - On the step that makes the fill count equal FILL_STEPS -> RUN.
  - `duty_load`=0 throughout.
- RUN:
  - Divider runs as in FILL.
  - On each `step` cycle, `duty_out` <= `duty_in`; `duty_load`=1 on the following cycle.
  - Pending slot full on a step cycle:
    - `hitless`=1: `tgt_out` <= pending and the slot empties; stay in RUN.
    - `hitless`=0: -> FLUSH instead of capturing duty.
- `en`=0 in any state -> IDLE next cycle.
  - `duty_out` and `tgt_out` hold.
  - The pending slot is kept.
  - An in-progress FILL is abandoned.
- Handshake:
  - `tgt_ack` pulses the cycle after `tgt_req`=1 is seen with the slot empty, in any state; `tgt_data` is latched at that point.
  - While the slot is full, requests wait; no ack.
  - The requester drops `tgt_req` after the ack. A `tgt_req` still high in the ack cycle is not a second request.
- Simultaneous events:
  - Slot emptying and a new request in the same cycle: the request is acked the next cycle.
  - `en` falling on a step cycle: no step is issued and no duty is captured.
- `div`=0: step every cycle. A `div` change takes effect at the next reload.

## Timing
- `en` rises, sampled at edge 0:
  - FLUSH / `clr` in cycle 1.
  - FILL from cycle 2.
  - First `step` in cycle 2+`div`.
  - RUN after step number FILL_STEPS.
- Duty pipeline:
  - First `duty_out` capture happens on the first RUN step.
  - `duty_load` is asserted one cycle after the capture.
  - With `div`=D, that is cycle 2+(FILL_STEPS+1)(D+1).
- All outputs are registered; no combinational path from input to output.
- Reset mid-operation: outputs go to reset values immediately, asynchronously.

## Structure
- Package `mash_pkg`:
  - `mash_state_t` enum for the four states.
  - `MASH_FILL_STEPS`=4.
  - `MASH_TGT_W`=32.
  - `MASH_TGT_PREFIX`=24'h4995cd, the default upper target bits used by the top level.
- Sub-module `stepgen`: DIV_W down-counter with synchronous load and `step` output, reused for the LED refresh tick.
- Main FSM, pending slot and duty register live in `mash_ctrl`.

## Test plan
- Reset with `en`=0 -> all outputs 0 and `state`=0 for 20 cycles.
- `div`=3, `en`=1 at cycle 0:
  - `clr` at cycle 1.
  - Steps at cycles 5, 9, 13, 17, 21.
  - `duty_in`=16'h1234 captured at 21; `duty_load` at 22.
- In RUN with `hitless`=0, offer `tgt_data`=32'h4995cd80:
  - `tgt_ack` 1 cycle after the request.
  - FLUSH at the next step, with `tgt_out` updated there.
  - `busy` high for 1+4(`div`+1) cycles.
- Same as above with `hitless`=1 -> `tgt_out` updates on the step cycle, no `clr`, `duty_load` continues every step.
- Two back-to-back requests while in IDLE -> first acked; second waits, unacked, until FLUSH empties the slot, then acked the following cycle.
- `en` drops mid-FILL, then `rst_n` pulses low mid-RUN:
  - IDLE next cycle, no further steps.
  - On the reset, outputs clear asynchronously.
